// File: rtl/cnt_seq_ctrl.sv
// Command sequencer for a 4-bit loadable up/down counter: load, step N times, report count and wraps.
// Optional abort of a running sequence is enabled by defining CNT_SEQ_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | counter load pulse (load_n low) with start value on cnt_d
// RUN   | counter enabled, one step per cycle, remaining-step timer counting down
// FLUSH | counter disabled, last step and carry settle
// DONE  | one-cycle done pulse, results valid
module cnt_seq_ctrl #(
   parameter int W  = 4,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          mr,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [W-1:0]  cmd_start,
   input  logic          cmd_dir,
   input  logic [LW-1:0] cmd_len,
   input  logic          cmd_abort,
   output logic          cnt_load_n,
   output logic          cnt_en,
   output logic          cnt_up_dn,
   output logic [W-1:0]  cnt_d,
   input  logic [W-1:0]  cnt_q,
   input  logic          cnt_co,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  res_q,
   output logic [3:0]    res_wraps,
   output logic          res_aborted
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [3:0]    wraps_q, wraps_d;
   logic          abort_q, abort_d;
   logic [W-1:0]  cnt_d_q, cnt_d_d;
   logic          up_dn_q, up_dn_d;
   logic          load_n_q;
   logic          en_q;
   logic          step_q;
   logic [W-1:0]  res_val_q;
   logic [3:0]    res_wraps_q;
   logic          res_ab_q;
   logic          abort_hit;

`ifdef CNT_SEQ_ABORT_EN
   assign abort_hit = cmd_abort;
`else
   logic unused_abort;
   assign unused_abort = cmd_abort;
   assign abort_hit    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      rem_d   = rem_q;
      wraps_d = wraps_q;
      abort_d = abort_q;
      cnt_d_d = cnt_d_q;
      up_dn_d = up_dn_q;
      // step_q marks that the counter stepped on the previous edge, so co now reflects that step
      if (step_q && cnt_co && (wraps_q != 4'hF)) begin
         wraps_d = wraps_q + 4'd1;
      end
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_LOAD;
               len_d   = cmd_len;
               cnt_d_d = cmd_start;
               up_dn_d = cmd_dir;
               wraps_d = 4'd0;
               abort_d = 1'b0;
            end
         end
         S_LOAD: begin
            rem_d   = len_q;
            state_d = (len_q == '0) ? S_FLUSH : S_RUN;
         end
         S_RUN: begin
            if (abort_hit) begin
               state_d = S_FLUSH;
               abort_d = 1'b1;
            end else if (rem_q == LW'(1)) begin
               state_d = S_FLUSH;
            end else begin
               rem_d = rem_q - LW'(1);
            end
         end
         S_FLUSH: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge mr) begin
      if (mr) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         rem_q       <= '0;
         wraps_q     <= 4'd0;
         abort_q     <= 1'b0;
         cnt_d_q     <= '0;
         up_dn_q     <= 1'b0;
         load_n_q    <= 1'b1;
         en_q        <= 1'b0;
         step_q      <= 1'b0;
         res_val_q   <= '0;
         res_wraps_q <= 4'd0;
         res_ab_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         rem_q    <= rem_d;
         wraps_q  <= wraps_d;
         abort_q  <= abort_d;
         cnt_d_q  <= cnt_d_d;
         up_dn_q  <= up_dn_d;
         load_n_q <= (state_d != S_LOAD);
         en_q     <= (state_d == S_RUN);
         step_q   <= en_q;
         if (state_q == S_FLUSH) begin
            res_val_q   <= cnt_q;
            res_wraps_q <= wraps_d;
            res_ab_q    <= abort_q;
         end
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign cnt_load_n  = load_n_q;
   assign cnt_en      = en_q;
   assign cnt_up_dn   = up_dn_q;
   assign cnt_d       = cnt_d_q;
   assign res_q       = res_val_q;
   assign res_wraps   = res_wraps_q;
   assign res_aborted = res_ab_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: behavioural lab counter, directed table, random commands vs arithmetic model.
module tb_cnt_seq_ctrl;

   logic       clk = 1'b0;
   logic       mr;
   logic       cmd_valid, cmd_ready, cmd_dir, cmd_abort;
   logic [3:0] cmd_start;
   logic [7:0] cmd_len;
   logic       cnt_load_n, cnt_en, cnt_up_dn, cnt_co;
   logic [3:0] cnt_d, cnt_q;
   logic       busy, done, res_aborted;
   logic [3:0] res_q, res_wraps;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cnt_seq_ctrl #(.W(4), .LW(8)) dut (
      .clk(clk), .mr(mr),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
      .cnt_load_n(cnt_load_n), .cnt_en(cnt_en), .cnt_up_dn(cnt_up_dn), .cnt_d(cnt_d),
      .cnt_q(cnt_q), .cnt_co(cnt_co),
      .busy(busy), .done(done),
      .res_q(res_q), .res_wraps(res_wraps), .res_aborted(res_aborted)
   );

   // lab counter: async active-low load, registered carry/borrow flag
   always @(posedge clk or posedge mr or negedge cnt_load_n) begin
      if (mr) begin
         cnt_q  <= 4'd0;
         cnt_co <= 1'b0;
      end else if (!cnt_load_n) begin
         cnt_q  <= cnt_d;
         cnt_co <= 1'b0;
      end else if (cnt_en) begin
         if (!cnt_up_dn) begin
            cnt_co <= (cnt_q == 4'hF);
            cnt_q  <= cnt_q + 4'd1;
         end else begin
            cnt_co <= (cnt_q == 4'h0);
            cnt_q  <= cnt_q - 4'd1;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // all outputs packed; reset value: ready=1, load_n=1, everything else 0
   task automatic chk_reset(input string nm);
      logic [19:0] v;
      v = {cmd_ready, busy, done, cnt_load_n, cnt_en, cnt_up_dn, cnt_d, res_q, res_wraps, res_aborted};
      chk(nm, int'(v), int'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0}));
   endtask

   function automatic int model_q(int s, int d, int l);
      return d ? ((s - l) & 15) : ((s + l) & 15);
   endfunction

   function automatic int model_wraps(int s, int d, int l);
      int w;
      w = d ? (15 - s + l) / 16 : (s + l) / 16;
      return (w > 15) ? 15 : w;
   endfunction

   // issue one command from idle; abort_at = k asserts cmd_abort during the k-th RUN cycle (0 = never)
   task automatic run_cmd(input logic [3:0] st, input logic dr, input logic [7:0] ln, input int abort_at,
                          output int edges, output int en_cyc, output int dir_bad,
                          output int rq, output int rw, output int ra, output int nd, output int nr);
      int n;
      cmd_start = st; cmd_dir = dr; cmd_len = ln; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n = 0; en_cyc = 0; dir_bad = 0; edges = -1;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (cnt_en) begin
            en_cyc++;
            if (cnt_up_dn !== dr) dir_bad++;
         end
         cmd_abort = (abort_at > 0 && n == abort_at + 1);
         if (done) begin
            edges = n - 1;
            break;
         end
      end
      cmd_abort = 1'b0;
      rq = int'(res_q); rw = int'(res_wraps); ra = int'(res_aborted);
      @(negedge clk);
      nd = int'(done); nr = int'(cmd_ready);
   endtask

   typedef struct {
      logic [3:0] st;
      logic       dr;
      logic [7:0] ln;
      logic [3:0] eq;
      logic [3:0] ew;
   } vec_t;

   vec_t tbl[5];

   task automatic check_cmd(input string tag, input logic [3:0] st, input logic dr, input logic [7:0] ln,
                            input int eq, input int ew, input int elat, input int eab, input int een, input int abort_at);
      int edges, en_cyc, dir_bad, rq, rw, ra, nd, nr;
      run_cmd(st, dr, ln, abort_at, edges, en_cyc, dir_bad, rq, rw, ra, nd, nr);
      chk({tag, " latency"}, edges, elat);
      chk({tag, " res_q"}, rq, eq);
      chk({tag, " res_wraps"}, rw, ew);
      chk({tag, " res_aborted"}, ra, eab);
      chk({tag, " en_cycles"}, en_cyc, een);
      chk({tag, " dir_in_run"}, dir_bad, 0);
      chk({tag, " done_1cycle"}, nd, 0);
      chk({tag, " ready_after"}, nr, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d, l, i0, i1, n, dn_cnt, done_at;
      mr = 1'b1; cmd_valid = 1'b0; cmd_start = 4'd0; cmd_dir = 1'b0; cmd_len = 8'd0; cmd_abort = 1'b0;
      tbl[0] = '{4'd14, 1'b0, 8'd5,   4'd3,  4'd1};
      tbl[1] = '{4'd1,  1'b1, 8'd3,   4'd14, 4'd1};
      tbl[2] = '{4'd9,  1'b0, 8'd0,   4'd9,  4'd0};
      tbl[3] = '{4'd0,  1'b0, 8'd255, 4'd15, 4'd15};
      tbl[4] = '{4'd0,  1'b0, 8'd20,  4'd4,  4'd1};

      #12 chk_reset("reset_state");
      @(negedge clk) mr = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         check_cmd($sformatf("tbl%0d", i), tbl[i].st, tbl[i].dr, tbl[i].ln,
                   int'(tbl[i].eq), int'(tbl[i].ew), int'(tbl[i].ln) + 2, 0, int'(tbl[i].ln), 0);
      end

`ifdef CNT_SEQ_ABORT_EN
      check_cmd("abort", 4'd0, 1'b0, 8'd100, 4, 0, 6, 1, 4, 4);
`else
      check_cmd("abort_ignored", 4'd0, 1'b0, 8'd100, 4, 6, 102, 0, 100, 4);
`endif

      for (int k = 0; k < 40; k++) begin
         s = int'($urandom_range(0, 15));
         d = int'($urandom_range(0, 1));
         l = (k % 8 == 7) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
         check_cmd($sformatf("rnd%0d", k), 4'(s), d[0], 8'(l),
                   model_q(s, d, l), model_wraps(s, d, l), l + 2, 0, l, 0);
      end

      // reset in the middle of RUN: immediate reset values and no done afterwards
      cmd_start = 4'd3; cmd_dir = 1'b0; cmd_len = 8'd50; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy_before_mr", int'(busy), 1);
      mr = 1'b1;
      #1 chk_reset("mr_mid_run");
      @(negedge clk);
      chk_reset("mr_held");
      mr = 1'b0;
      dn_cnt = 0;
      repeat (70) begin
         @(negedge clk);
         if (done) dn_cnt++;
      end
      chk("no_done_after_mr", dn_cnt, 0);

      // cmd_valid held high: next accept only on the first IDLE edge after DONE
      cmd_start = 4'd5; cmd_dir = 1'b1; cmd_len = 8'd3; cmd_valid = 1'b1;
      i0 = -1; i1 = -1; done_at = -1;
      for (n = 0; n < 40; n++) begin
         if (cmd_ready) begin
            if (i0 < 0) i0 = n;
            else if (i1 < 0) i1 = n;
         end
         if (done && done_at < 0) done_at = n;
         @(negedge clk);
      end
      chk("held_valid_period", i1 - i0, 7);
      chk("held_valid_done_pos", done_at - i0, 6);
      cmd_valid = 1'b0;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idle_after_held", int'(cmd_ready), 1);
      check_cmd("final_down", 4'd0, 1'b1, 8'd17, 15, 2, 19, 0, 17, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
